// File: rtl/mux_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mux_pkg
// Purpose  : Shared constants and select type for the structural 4:1 mux.
// Revision : 1.0 - initial release
// ============================================================================
package mux_pkg;

  // Number of data lanes feeding the mux tree.
  localparam int NUM_IN = 4;

  // Width of the lane select; log2(NUM_IN).
  localparam int SEL_W = 2;

  // Lane select: bit 0 picks within a pair, bit 1 picks between pairs.
  typedef logic [SEL_W-1:0] sel_t;

  // Named select codes, handy when reading waveforms or writing stimulus.
  localparam sel_t SEL_LANE0 = 2'b00;
  localparam sel_t SEL_LANE1 = 2'b01;
  localparam sel_t SEL_LANE2 = 2'b10;
  localparam sel_t SEL_LANE3 = 2'b11;

endpackage : mux_pkg
`default_nettype wire

// File: rtl/mux_2to1_st.sv
`default_nettype none
// ============================================================================
// Module   : mux_2to1_st
// Purpose  : Gate-level 2:1 multiplexer, WIDTH bits wide, shared select.
//            sel=0 passes a, sel=1 passes b.
// Revision : 1.0 - initial release
// ============================================================================
module mux_2to1_st
  import mux_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sel,
  output logic [WIDTH-1:0] y
);

  logic             w_sel_n;
  logic [WIDTH-1:0] w_pick_a;
  logic [WIDTH-1:0] w_pick_b;

  // Inverted select gates the a-side AND term.
  assign w_sel_n = ~sel;

  // AND terms: each bit of a and b is gated by the replicated select so
  // every bit is steered independently by the same control.
  assign w_pick_a = a & {WIDTH{w_sel_n}};
  assign w_pick_b = b & {WIDTH{sel}};

  // OR the two gated terms; exactly one is live for any known sel.
  assign y = w_pick_a | w_pick_b;

endmodule : mux_2to1_st
`default_nettype wire

// File: rtl/mux_4to1_st.sv
`default_nettype none
// ============================================================================
// Module   : mux_4to1_st
// Purpose  : Structural 4:1 mux built from three 2:1 gate-level muxes, with
//            a combinational output and a registered (1-cycle) output.
//            Lane k occupies I[k*WIDTH +: WIDTH].
// Revision : 1.0 - initial release
// ============================================================================
module mux_4to1_st
  import mux_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_IN*WIDTH-1:0] I,
  input  logic [SEL_W-1:0]        s,
  output logic [WIDTH-1:0]        y_comb,
  output logic [WIDTH-1:0]        y
);

  sel_t             w_sel;
  logic [WIDTH-1:0] w_lane [NUM_IN];
  logic [WIDTH-1:0] w_pair_lo;
  logic [WIDTH-1:0] w_pair_hi;
  logic [WIDTH-1:0] w_y_comb;
  logic [WIDTH-1:0] r_y;

  assign w_sel = s;

  // Unpack the flat input bus into individual lanes.
  for (genvar k = 0; k < NUM_IN; k++) begin : g_lane
    assign w_lane[k] = I[k*WIDTH +: WIDTH];
  end

  // First stage: s[0] chooses inside each pair (lane0/lane1, lane2/lane3).
  mux_2to1_st #(
    .WIDTH (WIDTH)
  ) u_mux_lo (
    .a   (w_lane[0]),
    .b   (w_lane[1]),
    .sel (w_sel[0]),
    .y   (w_pair_lo)
  );

  mux_2to1_st #(
    .WIDTH (WIDTH)
  ) u_mux_hi (
    .a   (w_lane[2]),
    .b   (w_lane[3]),
    .sel (w_sel[0]),
    .y   (w_pair_hi)
  );

  // Second stage: s[1] chooses between the two pair results.
  mux_2to1_st #(
    .WIDTH (WIDTH)
  ) u_mux_out (
    .a   (w_pair_lo),
    .b   (w_pair_hi),
    .sel (w_sel[1]),
    .y   (w_y_comb)
  );

  // Output register: reloads every cycle, cleared asynchronously so a reset
  // drops any in-flight sample without needing a clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_y <= '0;
    end else begin
      r_y <= w_y_comb;
    end
  end

  assign y_comb = w_y_comb;
  assign y      = r_y;

endmodule : mux_4to1_st
`default_nettype wire

// File: tb/tb_mux_4to1_st.sv
`default_nettype none
// ============================================================================
// Module   : tb_mux_4to1_st
// Purpose  : Self-checking bench for mux_4to1_st (WIDTH=1 and WIDTH=8).
// Revision : 1.0 - initial release
// ============================================================================
module tb_mux_4to1_st;

  typedef struct {
    logic [3:0] i;
    logic [1:0] s;
    logic       exp;
  } vec1_t;

  typedef struct {
    logic [31:0] i;
    logic [1:0]  s;
    logic [7:0]  exp;
  } vec8_t;

  logic        clk;
  logic        rst_n;
  logic [3:0]  i_n;
  logic [1:0]  s_n;
  logic        y_comb_n;
  logic        y_n;
  logic [31:0] i_w;
  logic [1:0]  s_w;
  logic [7:0]  y_comb_w;
  logic [7:0]  y_w;

  int n_chk;
  int n_fail;
  logic prev_exp;

  mux_4to1_st #(.WIDTH(1)) u_dut_n (
    .clk    (clk),
    .rst_n  (rst_n),
    .I      (i_n),
    .s      (s_n),
    .y_comb (y_comb_n),
    .y      (y_n)
  );

  mux_4to1_st #(.WIDTH(8)) u_dut_w (
    .clk    (clk),
    .rst_n  (rst_n),
    .I      (i_w),
    .s      (s_w),
    .y_comb (y_comb_w),
    .y      (y_w)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Safety net so the run can never hang.
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Drive one narrow vector between edges, check the combinational path at
  // once and the register both before and after the next rising edge.
  task automatic apply1(input string name, input logic [3:0] iv, input logic [1:0] sv,
                        input logic exp);
    @(negedge clk);
    i_n = iv;
    s_n = sv;
    #1;
    check({name, " y_comb"}, {7'd0, y_comb_n}, {7'd0, exp});
    check({name, " y_hold"}, {7'd0, y_n}, {7'd0, prev_exp});
    @(posedge clk);
    #1;
    check({name, " y"}, {7'd0, y_n}, {7'd0, exp});
    prev_exp = exp;
  endtask

  initial begin
    vec1_t tab1 [10];
    vec8_t tab8 [4];
    logic [3:0] iv;
    logic [1:0] sv;
    logic [5:0] nb;

    tab1[0] = '{i: 4'b0101, s: 2'b00, exp: 1'b1};
    tab1[1] = '{i: 4'b0101, s: 2'b01, exp: 1'b0};
    tab1[2] = '{i: 4'b0101, s: 2'b10, exp: 1'b1};
    tab1[3] = '{i: 4'b0101, s: 2'b11, exp: 1'b0};
    tab1[4] = '{i: 4'b1000, s: 2'b11, exp: 1'b1};
    tab1[5] = '{i: 4'b0111, s: 2'b11, exp: 1'b0};
    tab1[6] = '{i: 4'b1110, s: 2'b00, exp: 1'b0};
    tab1[7] = '{i: 4'b0001, s: 2'b00, exp: 1'b1};
    tab1[8] = '{i: 4'b0010, s: 2'b01, exp: 1'b1};
    tab1[9] = '{i: 4'b0100, s: 2'b10, exp: 1'b1};

    tab8[0] = '{i: {8'h00, 8'hFF, 8'h3C, 8'hA5}, s: 2'b00, exp: 8'hA5};
    tab8[1] = '{i: {8'h00, 8'hFF, 8'h3C, 8'hA5}, s: 2'b01, exp: 8'h3C};
    tab8[2] = '{i: {8'h00, 8'hFF, 8'h3C, 8'hA5}, s: 2'b10, exp: 8'hFF};
    tab8[3] = '{i: {8'h00, 8'hFF, 8'h3C, 8'hA5}, s: 2'b11, exp: 8'h00};

    n_chk  = 0;
    n_fail = 0;

    // Reset asserted before any clock edge (first rising edge is at t=5).
    rst_n = 1'b1;
    i_n   = 4'b1111;
    s_n   = 2'b11;
    i_w   = {8'h00, 8'hFF, 8'h3C, 8'hA5};
    s_w   = 2'b10;
    #1 rst_n = 1'b0;
    #1;
    check("reset y no edge", {7'd0, y_n}, 8'h00);
    check("reset y_comb", {7'd0, y_comb_n}, 8'h01);
    check("reset wide y", y_w, 8'h00);
    check("reset wide y_comb", y_comb_w, 8'hFF);

    // y_comb keeps following inputs while reset is held; y stays zero.
    i_n = 4'b1110;
    s_n = 2'b00;
    #1;
    check("reset follow y_comb", {7'd0, y_comb_n}, 8'h00);
    @(posedge clk);
    #1;
    check("reset hold y", {7'd0, y_n}, 8'h00);
    check("reset hold wide y", y_w, 8'h00);

    // Release between edges: y waits for the first rising edge.
    @(negedge clk);
    rst_n = 1'b1;
    i_n   = 4'b1111;
    #1;
    check("release y before edge", {7'd0, y_n}, 8'h00);
    check("release wide y before edge", y_w, 8'h00);
    @(posedge clk);
    #1;
    check("release y after edge", {7'd0, y_n}, 8'h01);
    check("wide y s=10", y_w, 8'hFF);
    prev_exp = 1'b1;

    // Directed table: lane walk plus single-hot / single-cold patterns.
    for (int k = 0; k < 10; k++) begin
      apply1($sformatf("tab[%0d]", k), tab1[k].i, tab1[k].s, tab1[k].exp);
    end

    // Exhaustive sweep over {I[0],I[1],I[2],I[3],s[0],s[1]} as a 6-bit count.
    for (int n = 0; n < 64; n++) begin
      nb    = 6'(n);
      iv[0] = nb[5];
      iv[1] = nb[4];
      iv[2] = nb[3];
      iv[3] = nb[2];
      sv[0] = nb[1];
      sv[1] = nb[0];
      apply1($sformatf("exh[%0d]", n), iv, sv, iv[sv]);
    end

    // Mid-stream reset: drop between edges, then release and recover.
    apply1("mid load", 4'b1000, 2'b11, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("mid reset y immediate", {7'd0, y_n}, 8'h00);
    check("mid reset y_comb", {7'd0, y_comb_n}, 8'h01);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("mid release y before edge", {7'd0, y_n}, 8'h00);
    @(posedge clk);
    #1;
    check("mid release y after edge", {7'd0, y_n}, 8'h01);

    // Wide lanes: every select value.
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      i_w = tab8[k].i;
      s_w = tab8[k].s;
      #1;
      check($sformatf("wide[%0d] y_comb", k), y_comb_w, tab8[k].exp);
      @(posedge clk);
      #1;
      check($sformatf("wide[%0d] y", k), y_w, tab8[k].exp);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule : tb_mux_4to1_st
`default_nettype wire

// File: doc/mux_4to1_st.md
MUX_4TO1_ST -- requirements
Module: mux_4to1_st

Interface
REQ-001 The block SHALL have parameter `WIDTH`, default 1: bit width of each data lane.
REQ-002 The block SHALL have port `clk`, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port `rst_n`, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port `I`, input, 4*WIDTH bits: four data lanes; lane k occupies I[k*WIDTH +: WIDTH] (WIDTH=1: lane k = I[k]).
REQ-005 The block SHALL have port `s`, input, 2 bits: lane select; s[1] is the MSB.
REQ-006 The block SHALL have port `y_comb`, output, WIDTH bits: combinational selected lane.
REQ-007 The block SHALL have port `y`, output, WIDTH bits: registered selected lane.

Function
REQ-008 y_comb SHALL equal lane s of I, purely combinationally, with no clock dependence: s=00->lane0, 01->lane1, 10->lane2, 11->lane3.
REQ-009 y SHALL capture y_comb on every rising clk edge while rst_n=1, giving exactly 1-cycle latency from I/s to y.
REQ-010 No enable or hold input SHALL exist; y SHALL reload every cycle.
REQ-011 A change on I or s between edges SHALL affect y_comb immediately and y only at the next rising edge.
REQ-012 Every select value SHALL be decoded: the block SHALL have no default/illegal case and SHALL produce no X output for known inputs.
REQ-013 Selection SHALL be gate-level structural, using AND/OR/NOT primitives or a 2:1 sub-mux tree, with no behavioural case or ternary at the top level.
REQ-014 The tree SHALL use s[0] to choose within the pairs (lane0/lane1, lane2/lane3) and s[1] to choose between the pair results.
REQ-015 Each bit of WIDTH SHALL be selected independently by the same s.

Reset
REQ-016 rst_n=0 SHALL force y to all-zeros immediately, without waiting for a clock edge.
REQ-017 While rst_n=0, y SHALL stay zero.
REQ-018 y_comb SHALL continue to follow I/s during reset.
REQ-019 On rst_n deassertion, y SHALL remain 0 until the first rising clk edge with rst_n=1, which SHALL load y_comb.
REQ-020 Assertion of rst_n mid-operation SHALL discard the pending sample and SHALL require no recovery sequence.

Structure
REQ-021 A shared package `mux_pkg` SHALL hold constants NUM_IN=4 and SEL_W=2, plus a typedef for the select type.
REQ-022 One sub-module, `mux_2to1_st` (inputs a, b, sel; output y; WIDTH-parameterised; gate-level), SHALL be instantiated three times to form the tree.
REQ-023 The output register SHALL live in the top-level module.

Verification
REQ-024 Reset: WIDTH=1, rst_n=0, I=4'b1111, s=2'b11 -> y=0 without any clk edge, y_comb=1.
REQ-025 Lane walk: rst_n=1, I=4'b0101, s=00/01/10/11 on successive cycles -> y_comb=1/0/1/0 immediately; y=1/0/1/0 one edge later.
REQ-026 Exhaustive: all 64 combinations of {I[0],I[1],I[2],I[3],s[0],s[1]}, 0 to 63, one per clock -> y_comb=I[s] each step, and y matches the prior step's y_comb.
REQ-027 Mid-stream reset: I=4'b1000, s=11, y=1; drop rst_n between edges -> y=0 at once; release rst_n -> y=1 after the next edge.
REQ-028 Wide lanes: WIDTH=8, lanes 8'hA5, 8'h3C, 8'hFF, 8'h00, s=10 -> y_comb=8'hFF, y=8'hFF after one edge.
